// File: rtl/pipelined_addsub_wrapper.sv
// pipelined_addsub_wrapper
//   Pipelined add/subtract unit. The arithmetic result (sum/difference,
//   carry-or-borrow, signed overflow) is formed when an operation is
//   accepted. It then travels down LATENCY-1 internal stages together with
//   its valid bit and caller tag, and lands in the output registers.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   ce              clock enable; low freezes the whole pipeline
//   in_valid        request, accepted on an edge with in_valid & ce
//   op_sub          0: A+B, 1: A-B
//   A, B            operands (WIDTH bits)
//   in_tag          caller tag, returned with the result
//   out_valid       one-cycle pulse per completed operation
//   S, cout, ovf    result, carry (add) / borrow (sub), signed overflow
//   out_tag         tag of the result
//   in_flight       accepted operations not yet reported
//   idle            in_flight == 0
module pipelined_addsub_wrapper #(
  parameter int WIDTH   = 64,
  parameter int LATENCY = 6,
  parameter int TAG_W   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ce,
  input  logic                           in_valid,
  input  logic                           op_sub,
  input  logic [WIDTH-1:0]               A,
  input  logic [WIDTH-1:0]               B,
  input  logic [TAG_W-1:0]               in_tag,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               S,
  output logic                           cout,
  output logic                           ovf,
  output logic [TAG_W-1:0]               out_tag,
  output logic [$clog2(LATENCY+1)-1:0]   in_flight,
  output logic                           idle
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t           in_stage;
  stage_t           last_stage;
  stage_t           out_d, out_q;
  logic [WIDTH:0]   ext_res;

  // Bit WIDTH of the zero-extended sum is the carry; of the zero-extended
  // difference it is the borrow (set iff A < B unsigned).
  always_comb begin
    if (op_sub) ext_res = {1'b0, A} - {1'b0, B};
    else        ext_res = {1'b0, A} + {1'b0, B};

    in_stage       = '0;
    in_stage.valid = in_valid;
    in_stage.s     = ext_res[WIDTH-1:0];
    in_stage.cout  = ext_res[WIDTH];
    if (op_sub)
      in_stage.ovf = (A[WIDTH-1] != B[WIDTH-1]) && (ext_res[WIDTH-1] != A[WIDTH-1]);
    else
      in_stage.ovf = (A[WIDTH-1] == B[WIDTH-1]) && (ext_res[WIDTH-1] != A[WIDTH-1]);
    in_stage.tag   = in_tag;
  end

  if (LATENCY > 1) begin : g_pipe
    localparam int unsigned DEPTH = LATENCY - 1;

    stage_t pipe_d [DEPTH];
    stage_t pipe_q [DEPTH];

    always_comb begin
      pipe_d = pipe_q;
      if (ce) begin
        pipe_d[0] = in_stage;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) pipe_q <= '{default: '0};
      else     pipe_q <= pipe_d;
    end

    assign last_stage = pipe_q[DEPTH-1];
  end else begin : g_direct
    assign last_stage = in_stage;
  end

  // Data registers hold while ce is low, but the valid bit is cleared so a
  // stalled result is not reported a second time.
  always_comb begin
    out_d       = out_q;
    out_d.valid = 1'b0;
    if (ce) out_d = last_stage;
  end

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign out_valid = out_q.valid;
  assign S         = out_q.s;
  assign cout      = out_q.cout;
  assign ovf       = out_q.ovf;
  assign out_tag   = out_q.tag;

  logic             accept, retire;
  logic [CNT_W-1:0] in_flight_d, in_flight_q;

  assign accept = in_valid & ce;
  assign retire = out_q.valid;

  always_comb begin
    in_flight_d = in_flight_q;
    if (accept && !retire)      in_flight_d = in_flight_q + CNT_W'(1);
    else if (!accept && retire) in_flight_d = in_flight_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) in_flight_q <= '0;
    else     in_flight_q <= in_flight_d;
  end

  assign in_flight = in_flight_q;
  assign idle      = (in_flight_q == '0);

endmodule

// File: tb/tb_pipelined_addsub_wrapper.sv
// Testbench for pipelined_addsub_wrapper: a 64-bit/LATENCY=6 instance and
// an 8-bit/LATENCY=1 instance sharing clock and reset.
module tb_pipelined_addsub_wrapper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        ce = 1'b1, iv = 1'b0, sub = 1'b0;
  logic [63:0] a = '0, b = '0;
  logic [3:0]  tag = '0;
  logic        ov, cout, ovf, idle;
  logic [63:0] s;
  logic [3:0]  otag;
  logic [2:0]  infl;

  logic        ce1 = 1'b1, iv1 = 1'b0, sub1 = 1'b0;
  logic [7:0]  a1 = '0, b1 = '0;
  logic [3:0]  tag1 = '0;
  logic        ov1, cout1, ovf1, idle1;
  logic [7:0]  s1;
  logic [3:0]  otag1;
  logic [0:0]  infl1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic [3:0]  tag;
    int          due;
  } exp_t;

  exp_t q[$];

  pipelined_addsub_wrapper #(.WIDTH(64), .LATENCY(6), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(iv), .op_sub(sub),
    .A(a), .B(b), .in_tag(tag),
    .out_valid(ov), .S(s), .cout(cout), .ovf(ovf), .out_tag(otag),
    .in_flight(infl), .idle(idle)
  );

  pipelined_addsub_wrapper #(.WIDTH(8), .LATENCY(1), .TAG_W(4)) dut1 (
    .clk(clk), .rst(rst), .ce(ce1), .in_valid(iv1), .op_sub(sub1),
    .A(a1), .B(b1), .in_tag(tag1),
    .out_valid(ov1), .S(s1), .cout(cout1), .ovf(ovf1), .out_tag(otag1),
    .in_flight(infl1), .idle(idle1)
  );

  // Reference: wrap-around result, carry via unsigned wrap test, borrow via
  // magnitude compare, overflow via range check of the exact signed result.
  function automatic exp_t model64(logic [63:0] x, logic [63:0] y, logic o, logic [3:0] t);
    exp_t m;
    logic signed [65:0] sx, sy, f, hi, lo;
    m.s    = o ? (x - y) : (x + y);
    m.cout = o ? (x < y) : ((x + y) < x);
    sx = $signed({{2{x[63]}}, x});
    sy = $signed({{2{y[63]}}, y});
    f  = o ? (sx - sy) : (sx + sy);
    hi = $signed({3'b000, {63{1'b1}}});
    lo = $signed({3'b111, 63'd0});
    m.ovf = (f > hi) || (f < lo);
    m.tag = t;
    m.due = -1;
    return m;
  endfunction

  task automatic test_reset();
    logic seen;
    @(negedge clk); rst = 1'b1; ce = 1'b1; iv = 1'b0; ce1 = 1'b1; iv1 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    total++;
    if ({ov, s, cout, ovf, otag, infl, idle} !== {1'b0, 64'd0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state got ov=%b S=%h c=%b v=%b tag=%h infl=%0d idle=%b want all 0, idle=1",
               ov, s, cout, ovf, otag, infl, idle);
    end
    total++;
    if ({ov1, s1, cout1, ovf1, otag1, infl1, idle1} !== {1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state_l1 got ov=%b S=%h c=%b v=%b tag=%h infl=%0d idle=%b want all 0, idle=1",
               ov1, s1, cout1, ovf1, otag1, infl1, idle1);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); iv = 1'b1; sub = 1'b0; a = 64'(i + 1); b = 64'd5; tag = 4'(i);
      @(posedge clk); #1;
    end
    total++;
    if (infl !== 3'd3) begin
      bad++; $display("FAIL midstream_infl got %0d want 3", infl);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({ov, infl, idle} !== {1'b0, 3'd0, 1'b1}) begin
      bad++; $display("FAIL midstream_reset got ov=%b infl=%0d idle=%b want 0 0 1", ov, infl, idle);
    end
    @(negedge clk); rst = 1'b0; iv = 1'b0; a = '0; b = '0; tag = '0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ov) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL dropped_ops got pulse=%b want 0", seen);
    end
    total++;
    if ({ov, s, cout, ovf, otag, infl, idle} !== {1'b0, 64'd0, 1'b0, 1'b0, 4'd0, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL post_reset_outputs got ov=%b S=%h c=%b v=%b tag=%h infl=%0d idle=%b want all 0, idle=1",
               ov, s, cout, ovf, otag, infl, idle);
    end
  endtask

  task automatic test_single_add();
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ce = 1'b1;
      if (i == 0) begin
        iv = 1'b1; sub = 1'b0; a = '1; b = 64'd1; tag = 4'd5;
        q.push_back('{s: 64'd0, cout: 1'b1, ovf: 1'b0, tag: 4'd5, due: cyc + 6});
      end else iv = 1'b0;
      @(posedge clk); #1;
      if (ov) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL add_extra got S=%h want no pulse", s);
        end else begin
          e = q.pop_front();
          if ({s, cout, ovf, otag} !== {e.s, e.cout, e.ovf, e.tag} || cyc != e.due) begin
            bad++;
            $display("FAIL add_result got S=%h c=%b v=%b tag=%h cyc=%0d want S=%h c=%b v=%b tag=%h cyc=%0d",
                     s, cout, ovf, otag, cyc, e.s, e.cout, e.ovf, e.tag, e.due);
          end
        end
      end
    end
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL add_missing got %0d pending want 0", q.size()); q.delete();
    end
  endtask

  task automatic test_single_sub();
    exp_t e;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      ce = 1'b1; iv = 1'b0;
      if (i == 0) begin
        iv = 1'b1; sub = 1'b1; a = 64'd3; b = 64'd5; tag = 4'd1;
        q.push_back('{s: 64'hFFFF_FFFF_FFFF_FFFE, cout: 1'b1, ovf: 1'b0, tag: 4'd1, due: cyc + 6});
      end else if (i == 3) begin
        iv = 1'b1; sub = 1'b1; a = 64'h8000_0000_0000_0000; b = 64'd1; tag = 4'd2;
        q.push_back('{s: 64'h7FFF_FFFF_FFFF_FFFF, cout: 1'b0, ovf: 1'b1, tag: 4'd2, due: cyc + 6});
      end
      @(posedge clk); #1;
      if (ov) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL sub_extra got S=%h want no pulse", s);
        end else begin
          e = q.pop_front();
          if ({s, cout, ovf, otag} !== {e.s, e.cout, e.ovf, e.tag} || cyc != e.due) begin
            bad++;
            $display("FAIL sub_result got S=%h c=%b v=%b tag=%h cyc=%0d want S=%h c=%b v=%b tag=%h cyc=%0d",
                     s, cout, ovf, otag, cyc, e.s, e.cout, e.ovf, e.tag, e.due);
          end
        end
      end
    end
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL sub_missing got %0d pending want 0", q.size()); q.delete();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   peak = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ce = 1'b1;
      if (i < 8) begin
        iv = 1'b1; sub = i[0]; a = 64'(i); b = 64'(i); tag = 4'(i);
        q.push_back('{s: (i[0] ? 64'd0 : 64'(2 * i)), cout: 1'b0, ovf: 1'b0, tag: 4'(i), due: cyc + 6});
      end else iv = 1'b0;
      @(posedge clk); #1;
      if (int'(infl) > peak) peak = int'(infl);
      if (ov) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL b2b_extra got S=%h want no pulse", s);
        end else begin
          e = q.pop_front();
          if ({s, cout, ovf, otag} !== {e.s, e.cout, e.ovf, e.tag} || cyc != e.due) begin
            bad++;
            $display("FAIL b2b_result got S=%h c=%b v=%b tag=%h cyc=%0d want S=%h c=%b v=%b tag=%h cyc=%0d",
                     s, cout, ovf, otag, cyc, e.s, e.cout, e.ovf, e.tag, e.due);
          end
        end
      end
    end
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL b2b_missing got %0d pending want 0", q.size()); q.delete();
    end
    total++;
    if (peak != 6) begin
      bad++; $display("FAIL b2b_peak got %0d want 6", peak);
    end
    total++;
    if ({infl, idle} !== {3'd0, 1'b1}) begin
      bad++; $display("FAIL b2b_drain got infl=%0d idle=%b want 0 1", infl, idle);
    end
  endtask

  task automatic test_ce_stall();
    exp_t e;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) begin
        ce = 1'b1; iv = 1'b1; sub = 1'b0; a = 64'd10; b = 64'd20; tag = 4'd9;
        q.push_back('{s: 64'd30, cout: 1'b0, ovf: 1'b0, tag: 4'd9, due: cyc + 9});
      end else if (i >= 2 && i <= 4) begin
        ce = 1'b0; iv = 1'b1; a = 64'd1; b = 64'd1; tag = 4'hF;
      end else begin
        ce = 1'b1; iv = 1'b0;
      end
      @(posedge clk); #1;
      if (i >= 2 && i <= 4) begin
        total++;
        if ({ov, infl} !== {1'b0, 3'd1}) begin
          bad++; $display("FAIL stall_hold got ov=%b infl=%0d want 0 1", ov, infl);
        end
      end
      if (ov) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL stall_extra got S=%h tag=%h want no pulse", s, otag);
        end else begin
          e = q.pop_front();
          if ({s, cout, ovf, otag} !== {e.s, e.cout, e.ovf, e.tag} || cyc != e.due) begin
            bad++;
            $display("FAIL stall_result got S=%h c=%b v=%b tag=%h cyc=%0d want S=%h c=%b v=%b tag=%h cyc=%0d",
                     s, cout, ovf, otag, cyc, e.s, e.cout, e.ovf, e.tag, e.due);
          end
        end
      end
    end
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL stall_missing got %0d pending want 0", q.size()); q.delete();
    end
    total++;
    if ({infl, idle} !== {3'd0, 1'b1}) begin
      bad++; $display("FAIL stall_drain got infl=%0d idle=%b want 0 1", infl, idle);
    end
  endtask

  task automatic test_random();
    exp_t e;
    int   im = 0;
    logic acc, ret;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i < 45) begin
        ce  = ($urandom_range(0, 3) != 0);
        iv  = $urandom_range(0, 1);
        sub = $urandom_range(0, 1);
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        if (i % 5 == 0) b = a ^ 64'h8000_0000_0000_0000;
        tag = 4'($urandom);
      end else begin
        ce = 1'b1; iv = 1'b0;
      end
      acc = ce & iv;
      ret = ov;
      if (acc) q.push_back(model64(a, b, sub, tag));
      @(posedge clk); #1;
      im = im + int'(acc) - int'(ret);
      total++;
      if (int'(infl) != im) begin
        bad++; $display("FAIL rand_infl got %0d want %0d", infl, im);
      end
      if (ov) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand_extra got S=%h want no pulse", s);
        end else begin
          e = q.pop_front();
          if ({s, cout, ovf, otag} !== {e.s, e.cout, e.ovf, e.tag}) begin
            bad++;
            $display("FAIL rand_result got S=%h c=%b v=%b tag=%h want S=%h c=%b v=%b tag=%h",
                     s, cout, ovf, otag, e.s, e.cout, e.ovf, e.tag);
          end
        end
      end
    end
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL rand_missing got %0d pending want 0", q.size()); q.delete();
    end
  endtask

  task automatic test_latency1();
    @(negedge clk); ce1 = 1'b1; iv1 = 1'b1; sub1 = 1'b0; a1 = 8'h7F; b1 = 8'h01; tag1 = 4'd3;
    @(posedge clk); #1;
    total++;
    if ({ov1, s1, cout1, ovf1, otag1, infl1} !== {1'b1, 8'h80, 1'b0, 1'b1, 4'd3, 1'b1}) begin
      bad++; $display("FAIL l1_add got ov=%b S=%h c=%b v=%b tag=%h infl=%0d want 1 80 0 1 3 1",
                      ov1, s1, cout1, ovf1, otag1, infl1);
    end
    @(negedge clk); iv1 = 1'b1; sub1 = 1'b1; a1 = 8'h80; b1 = 8'h01; tag1 = 4'd6;
    @(posedge clk); #1;
    total++;
    if ({ov1, s1, cout1, ovf1, otag1, infl1} !== {1'b1, 8'h7F, 1'b0, 1'b1, 4'd6, 1'b1}) begin
      bad++; $display("FAIL l1_sub_ovf got ov=%b S=%h c=%b v=%b tag=%h infl=%0d want 1 7f 0 1 6 1",
                      ov1, s1, cout1, ovf1, otag1, infl1);
    end
    @(negedge clk); iv1 = 1'b1; sub1 = 1'b1; a1 = 8'h03; b1 = 8'h05; tag1 = 4'd7;
    @(posedge clk); #1;
    total++;
    if ({ov1, s1, cout1, ovf1, otag1, infl1} !== {1'b1, 8'hFE, 1'b1, 1'b0, 4'd7, 1'b1}) begin
      bad++; $display("FAIL l1_sub_borrow got ov=%b S=%h c=%b v=%b tag=%h infl=%0d want 1 fe 1 0 7 1",
                      ov1, s1, cout1, ovf1, otag1, infl1);
    end
    @(negedge clk); iv1 = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({ov1, infl1, idle1} !== {1'b0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL l1_retire got ov=%b infl=%0d idle=%b want 0 0 1", ov1, infl1, idle1);
    end
    @(negedge clk); ce1 = 1'b0; iv1 = 1'b1; a1 = 8'h11; b1 = 8'h22;
    @(posedge clk); #1;
    total++;
    if ({ov1, s1, infl1, idle1} !== {1'b0, 8'hFE, 1'b0, 1'b1}) begin
      bad++; $display("FAIL l1_ce_low got ov=%b S=%h infl=%0d idle=%b want 0 fe 0 1", ov1, s1, infl1, idle1);
    end
    @(negedge clk); ce1 = 1'b1; iv1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_single_sub();
    test_back_to_back();
    test_ce_stall();
    test_random();
    test_latency1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
